// File: rtl/octogen_udp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : octogen_udp_pkg
// Description : Shared state encoding, default UDP ports and the test-payload
//               pattern used by the UDP echo initiator TX generator and RX checker.
// Revision    : 1.0 - initial release
// ============================================================================
package octogen_udp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TX_HDR   = 3'd1,
        ST_TX_DATA  = 3'd2,
        ST_WAIT_RX  = 3'd3,
        ST_RX_CHECK = 3'd4,
        ST_RX_DRAIN = 3'd5,
        ST_GAP      = 3'd6
    } state_t;

    localparam logic [15:0] DEFAULT_SRC_PORT  = 16'd5000;
    localparam logic [15:0] DEFAULT_DEST_PORT = 16'd7;
    localparam int          IDX_W             = 11;

    // Bytes 0..3 carry the sequence number MSB first; later bytes ramp from seq[7:0].
    function automatic logic [7:0] pattern_byte(input logic [31:0] seq,
                                                input logic [IDX_W-1:0] idx);
        logic [7:0] b;
        case (idx)
            11'd0:   b = seq[31:24];
            11'd1:   b = seq[23:16];
            11'd2:   b = seq[15:8];
            11'd3:   b = seq[7:0];
            default: b = seq[7:0] + idx[7:0];
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/octogen_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : octogen_sat_counter
// Description : Statistics counter that increments on inc and holds at all-ones.
// Revision    : 1.0 - initial release
// ============================================================================
module octogen_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/udp_echo_initiator.sv
`default_nettype none
// ============================================================================
// Module      : udp_echo_initiator
// Description : Sends sequence-numbered test datagrams into the UDP stack and
//               checks each echoed reply; keeps statistics and last round-trip time.
// Revision    : 1.0 - initial release
// ============================================================================
module udp_echo_initiator
    import octogen_udp_pkg::*;
#(
    parameter int          PAYLOAD_LEN    = 64,
    parameter logic [15:0] SRC_PORT       = DEFAULT_SRC_PORT,
    parameter logic [15:0] DEST_PORT      = DEFAULT_DEST_PORT,
    parameter int          TIMEOUT_CYCLES = 125000,
    parameter int          GAP_CYCLES     = 1250
) (
    input  logic        axis_clk,
    input  logic        axis_rst_n,
    input  logic        enable,
    input  logic [31:0] dest_ip,
    output logic        udp_tx_hdr_valid,
    input  logic        udp_tx_hdr_ready,
    output logic [31:0] udp_tx_dest_ip,
    output logic [15:0] udp_tx_src_port,
    output logic [15:0] udp_tx_dest_port,
    output logic [7:0]  udp_tx_tdata,
    output logic        udp_tx_tvalid,
    input  logic        udp_tx_tready,
    output logic        udp_tx_tlast,
    input  logic        udp_rx_hdr_valid,
    output logic        udp_rx_hdr_ready,
    input  logic [31:0] udp_rx_src_ip,
    input  logic [15:0] udp_rx_src_port,
    input  logic [15:0] udp_rx_dest_port,
    input  logic [7:0]  udp_rx_tdata,
    input  logic        udp_rx_tvalid,
    output logic        udp_rx_tready,
    input  logic        udp_rx_tlast,
    output logic [31:0] tx_count,
    output logic [31:0] rx_ok_count,
    output logic [31:0] err_count,
    output logic [31:0] timeout_count,
    output logic [31:0] drop_count,
    output logic [31:0] last_rtt,
    output logic        busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = PAYLOAD_LEN[IDX_W-1:0] - 11'd1;
    localparam logic [31:0]      TMO_LAST = TIMEOUT_CYCLES[31:0] - 32'd1;
    // GAP lasts GAP_CYCLES cycles, but at least one so enable is always re-sampled there.
    localparam logic [31:0]      GAP_LAST = (GAP_CYCLES == 0) ? 32'd0 : (GAP_CYCLES[31:0] - 32'd1);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

    state_t           state_q, state_d;
    logic [31:0]      seq_q, seq_d;
    logic [31:0]      ip_q, ip_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      rtt_q, rtt_d;
    logic [31:0]      tmo_q, tmo_d;
    logic [31:0]      gap_q, gap_d;
    logic             err_q, err_d;
    logic [31:0]      last_rtt_q, last_rtt_d;
    logic             tx_hdr_valid_q, tx_hdr_valid_d;
    logic             tx_tvalid_q, tx_tvalid_d;
    logic [7:0]       tx_tdata_q, tx_tdata_d;
    logic             tx_tlast_q, tx_tlast_d;
    logic             rx_hdr_ready_q, rx_hdr_ready_d;
    logic             rx_tready_q, rx_tready_d;

    logic tx_inc, ok_inc, err_inc, tmo_inc, drop_inc;
    logic tx_hs, tx_beat, rx_hs, rx_beat, hdr_match, byte_err;

    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        ip_d       = ip_q;
        idx_d      = idx_q;
        rtt_d      = sat_inc(rtt_q);
        tmo_d      = sat_inc(tmo_q);
        gap_d      = gap_q;
        err_d      = err_q;
        last_rtt_d = last_rtt_q;
        tx_inc     = 1'b0;
        ok_inc     = 1'b0;
        err_inc    = 1'b0;
        tmo_inc    = 1'b0;
        drop_inc   = 1'b0;

        tx_hs     = tx_hdr_valid_q && udp_tx_hdr_ready;
        tx_beat   = tx_tvalid_q && udp_tx_tready;
        rx_hs     = rx_hdr_ready_q && udp_rx_hdr_valid;
        rx_beat   = rx_tready_q && udp_rx_tvalid;
        hdr_match = (udp_rx_src_ip == ip_q) && (udp_rx_src_port == DEST_PORT)
                    && (udp_rx_dest_port == SRC_PORT);
        // Wrong data, overrun, early tlast, or missing tlast on the final byte.
        byte_err  = (idx_q > LAST_IDX)
                    || (udp_rx_tdata != pattern_byte(seq_q, idx_q))
                    || (udp_rx_tlast != (idx_q == LAST_IDX));

        case (state_q)
            ST_IDLE: begin
                if (enable) begin
                    ip_d    = dest_ip;
                    idx_d   = '0;
                    state_d = ST_TX_HDR;
                end
            end
            ST_TX_HDR: begin
                if (tx_hs) begin
                    rtt_d   = '0;
                    tx_inc  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_TX_DATA;
                end
            end
            ST_TX_DATA: begin
                if (tx_beat) begin
                    if (idx_q == LAST_IDX) begin
                        tmo_d   = '0;
                        state_d = ST_WAIT_RX;
                    end else begin
                        idx_d = idx_q + 11'd1;
                    end
                end
            end
            ST_WAIT_RX: begin
                if (rx_hs) begin
                    idx_d = '0;
                    if (hdr_match) begin
                        last_rtt_d = rtt_q;
                        err_d      = 1'b0;
                        state_d    = ST_RX_CHECK;
                    end else begin
                        state_d = ST_RX_DRAIN;
                    end
                end else if (tmo_q >= TMO_LAST) begin
                    tmo_inc = 1'b1;
                    seq_d   = seq_q + 32'd1;
                    gap_d   = '0;
                    state_d = ST_GAP;
                end
            end
            ST_RX_CHECK: begin
                if (rx_beat) begin
                    if (byte_err) begin
                        err_d = 1'b1;
                    end
                    if (idx_q != {IDX_W{1'b1}}) begin
                        idx_d = idx_q + 11'd1;
                    end
                    if (udp_rx_tlast) begin
                        err_inc = err_q || byte_err;
                        ok_inc  = !(err_q || byte_err);
                        seq_d   = seq_q + 32'd1;
                        gap_d   = '0;
                        state_d = ST_GAP;
                    end
                end
            end
            ST_RX_DRAIN: begin
                if (rx_beat && udp_rx_tlast) begin
                    drop_inc = 1'b1;
                    state_d  = ST_WAIT_RX;
                end
            end
            ST_GAP: begin
                if (gap_q >= GAP_LAST) begin
                    if (enable) begin
                        ip_d    = dest_ip;
                        idx_d   = '0;
                        state_d = ST_TX_HDR;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    gap_d = gap_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Handshake outputs are registered from the next state so they hold while stalled.
        tx_hdr_valid_d = (state_d == ST_TX_HDR);
        tx_tvalid_d    = (state_d == ST_TX_DATA);
        tx_tdata_d     = pattern_byte(seq_d, idx_d);
        tx_tlast_d     = (state_d == ST_TX_DATA) && (idx_d == LAST_IDX);
        rx_hdr_ready_d = (state_d == ST_WAIT_RX);
        rx_tready_d    = (state_d == ST_RX_CHECK) || (state_d == ST_RX_DRAIN);
    end

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            state_q        <= ST_IDLE;
            seq_q          <= '0;
            ip_q           <= '0;
            idx_q          <= '0;
            rtt_q          <= '0;
            tmo_q          <= '0;
            gap_q          <= '0;
            err_q          <= 1'b0;
            last_rtt_q     <= '0;
            tx_hdr_valid_q <= 1'b0;
            tx_tvalid_q    <= 1'b0;
            tx_tdata_q     <= '0;
            tx_tlast_q     <= 1'b0;
            rx_hdr_ready_q <= 1'b0;
            rx_tready_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            ip_q           <= ip_d;
            idx_q          <= idx_d;
            rtt_q          <= rtt_d;
            tmo_q          <= tmo_d;
            gap_q          <= gap_d;
            err_q          <= err_d;
            last_rtt_q     <= last_rtt_d;
            tx_hdr_valid_q <= tx_hdr_valid_d;
            tx_tvalid_q    <= tx_tvalid_d;
            tx_tdata_q     <= tx_tdata_d;
            tx_tlast_q     <= tx_tlast_d;
            rx_hdr_ready_q <= rx_hdr_ready_d;
            rx_tready_q    <= rx_tready_d;
        end
    end

    octogen_sat_counter #(.WIDTH(32)) u_tx_cnt (
        .clk(axis_clk), .rst_n(axis_rst_n), .inc(tx_inc), .count(tx_count));
    octogen_sat_counter #(.WIDTH(32)) u_ok_cnt (
        .clk(axis_clk), .rst_n(axis_rst_n), .inc(ok_inc), .count(rx_ok_count));
    octogen_sat_counter #(.WIDTH(32)) u_err_cnt (
        .clk(axis_clk), .rst_n(axis_rst_n), .inc(err_inc), .count(err_count));
    octogen_sat_counter #(.WIDTH(32)) u_tmo_cnt (
        .clk(axis_clk), .rst_n(axis_rst_n), .inc(tmo_inc), .count(timeout_count));
    octogen_sat_counter #(.WIDTH(32)) u_drop_cnt (
        .clk(axis_clk), .rst_n(axis_rst_n), .inc(drop_inc), .count(drop_count));

    assign udp_tx_hdr_valid = tx_hdr_valid_q;
    assign udp_tx_dest_ip   = ip_q;
    assign udp_tx_src_port  = SRC_PORT;
    assign udp_tx_dest_port = DEST_PORT;
    assign udp_tx_tdata     = tx_tdata_q;
    assign udp_tx_tvalid    = tx_tvalid_q;
    assign udp_tx_tlast     = tx_tlast_q;
    assign udp_rx_hdr_ready = rx_hdr_ready_q;
    assign udp_rx_tready    = rx_tready_q;
    assign last_rtt         = last_rtt_q;
    assign busy             = (state_q != ST_IDLE);

endmodule
`default_nettype wire
